// File: rtl/exu_bp_stat_reader_pkg.sv
// rtl/exu_bp_stat_reader_pkg.sv - shared types for the branch-prediction statistics reader
package veer_types;

  localparam int BP_STAT_NUM = 6;

  // Counter indices in the order the sweep presents them
  typedef enum logic [2:0] {
    BP_PRED      = 3'd0,
    BP_CORRECT   = 3'd1,
    BP_MISPRED   = 3'd2,
    BP_COND_MISP = 3'd3,
    BP_TKP       = 3'd4,
    BP_NTKP      = 3'd5
  } bp_stat_idx_e;

  // One branch-resolution event from the ALU
  typedef struct packed {
    logic valid;
    logic predict_t;
    logic predict_nt;
    logic flush_upper;
    logic cond_mispredict;
  } bp_stat_ev_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_DUMP = 2'd1,
    DS_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/exu_bp_stat_reader_ctr.sv
// rtl/exu_bp_stat_reader_ctr.sv - plain flop and single statistic counter with wrap or saturate
module rvdff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Basic state flop, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= '0;
    else     dout <= din;
  end

endmodule

module bp_stat_ctr #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] q;
  logic [CNT_W-1:0] d;

  // Next value: clear beats increment; all-ones either wraps or sticks
  always_comb begin
    d = q;
    if (clr) begin
      d = '0;
    end else if (inc) begin
      if ((SATURATE != 0) && (&q)) d = q;
      else                         d = q + ONE;
    end
  end

  rvdff #(.WIDTH(CNT_W)) u_q (.clk(clk), .rst(rst), .din(d), .dout(q));

  assign cnt = q;

endmodule

// File: rtl/exu_bp_stat_reader.sv
// rtl/exu_bp_stat_reader.sv - branch-prediction statistic counters with random read and sweep stream (option: RV_BP_STAT_SNAPSHOT_EN)
module exu_bp_stat_reader
  import veer_types::*;
#(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             ev_valid,
  input  logic             ev_predict_t,
  input  logic             ev_predict_nt,
  input  logic             ev_flush_upper,
  input  logic             ev_cond_mispredict,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [2:0]       rd_addr,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  input  logic             dump_start,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [2:0]       dump_idx,
  output logic [CNT_W-1:0] dump_data,
  output logic             dump_busy
);

  bp_stat_ev_t ev;
  logic        g;
  logic        p;
  logic [BP_STAT_NUM-1:0] inc;
  logic [CNT_W-1:0] cnt [BP_STAT_NUM];
  logic [CNT_W-1:0] src [BP_STAT_NUM];
  logic [CNT_W-1:0] rd_sel;
  logic [CNT_W-1:0] beat_nxt;
  dump_state_e      state;
  logic             start_ok;

  assign ev = '{valid: ev_valid, predict_t: ev_predict_t, predict_nt: ev_predict_nt,
                flush_upper: ev_flush_upper, cond_mispredict: ev_cond_mispredict};

  assign g = ev.valid & ~flush & ~freeze;
  assign p = g & (ev.predict_t | ev.predict_nt);

  assign inc[BP_PRED]      = p;
  assign inc[BP_CORRECT]   = p & ~ev.flush_upper;
  assign inc[BP_MISPRED]   = p & ev.flush_upper;
  assign inc[BP_COND_MISP] = p & ev.cond_mispredict;
  assign inc[BP_TKP]       = g & ev.predict_t;
  assign inc[BP_NTKP]      = g & ev.predict_nt;

  assign start_ok = (state == DS_IDLE) & dump_start;

  for (genvar i = 0; i < BP_STAT_NUM; i++) begin : g_ctr
    bp_stat_ctr #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_ctr (
      .clk(clk), .rst(rst), .inc(inc[i]), .clr(clr), .cnt(cnt[i])
    );
`ifdef RV_BP_STAT_SNAPSHOT_EN
    // Shadow bank captured atomically at sweep start; clr leaves it alone
    logic [CNT_W-1:0] bank_d;
    assign bank_d = start_ok ? cnt[i] : src[i];
    rvdff #(.WIDTH(CNT_W)) u_bank (.clk(clk), .rst(rst), .din(bank_d), .dout(src[i]));
`else
    assign src[i] = cnt[i];
`endif
  end

  // Random-read mux; indices past the last counter read as zero
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < BP_STAT_NUM; i++) begin
      if (rd_addr == i[2:0]) rd_sel = cnt[i];
    end
  end

  rvdff #(.WIDTH(1))     u_rd_valid (.clk(clk), .rst(rst), .din(rd_req), .dout(rd_valid));
  rvdff #(.WIDTH(CNT_W)) u_rd_data  (.clk(clk), .rst(rst), .din(rd_req ? rd_sel : '0), .dout(rd_data));

  // Value for the beat that follows the current one, sampled when it first presents
  always_comb begin
    beat_nxt = '0;
    for (int i = 0; i < BP_STAT_NUM; i++) begin
      if (dump_idx + 3'd1 == i[2:0]) beat_nxt = src[i];
    end
  end

  // Sweep FSM; dump_data only loads when a new beat presents so stalls hold it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DS_IDLE;
      dump_valid <= 1'b0;
      dump_idx   <= 3'd0;
      dump_data  <= '0;
      dump_busy  <= 1'b0;
    end else begin
      case (state)
        DS_IDLE: begin
          if (dump_start) begin
            state      <= DS_DUMP;
            dump_valid <= 1'b1;
            dump_idx   <= 3'd0;
            dump_data  <= cnt[BP_PRED];
            dump_busy  <= 1'b1;
          end
        end
        DS_DUMP: begin
          if (dump_ready) begin
            if (dump_idx == 3'(BP_NTKP)) begin
              state      <= DS_DONE;
              dump_valid <= 1'b0;
              dump_data  <= '0;
            end else begin
              dump_idx  <= dump_idx + 3'd1;
              dump_data <= beat_nxt;
            end
          end
        end
        DS_DONE: begin
          state     <= DS_IDLE;
          dump_busy <= 1'b0;
        end
        default: begin
          state      <= DS_IDLE;
          dump_valid <= 1'b0;
          dump_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exu_bp_stat_reader.sv
// tb/tb_exu_bp_stat_reader.sv - directed self-checking bench for exu_bp_stat_reader
module tb_exu_bp_stat_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 0, flush = 0, ev_valid = 0, ev_predict_t = 0, ev_predict_nt = 0;
  logic        ev_flush_upper = 0, ev_cond_mispredict = 0, clr = 0, rd_req = 0;
  logic [2:0]  rd_addr = 0;
  logic        dump_start = 0, dump_ready = 0;
  logic        rd_valid, dump_valid, dump_busy;
  logic [31:0] rd_data, dump_data;
  logic [2:0]  dump_idx;

  logic        sev_valid = 0, srd_req = 0;
  logic        w_rd_valid, w_dump_valid, w_dump_busy, s_rd_valid, s_dump_valid, s_dump_busy;
  logic [3:0]  w_rd_data, w_dump_data, s_rd_data, s_dump_data;
  logic [2:0]  w_dump_idx, s_dump_idx;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  exu_bp_stat_reader #(.CNT_W(32), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .ev_valid(ev_valid),
    .ev_predict_t(ev_predict_t), .ev_predict_nt(ev_predict_nt), .ev_flush_upper(ev_flush_upper),
    .ev_cond_mispredict(ev_cond_mispredict), .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .dump_start(dump_start), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy)
  );

  exu_bp_stat_reader #(.CNT_W(4), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .freeze(1'b0), .flush(1'b0), .ev_valid(sev_valid),
    .ev_predict_t(1'b1), .ev_predict_nt(1'b0), .ev_flush_upper(1'b0),
    .ev_cond_mispredict(1'b0), .clr(1'b0), .rd_req(srd_req), .rd_addr(3'd0),
    .rd_valid(w_rd_valid), .rd_data(w_rd_data), .dump_start(1'b0), .dump_valid(w_dump_valid),
    .dump_ready(1'b0), .dump_idx(w_dump_idx), .dump_data(w_dump_data), .dump_busy(w_dump_busy)
  );

  exu_bp_stat_reader #(.CNT_W(4), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .freeze(1'b0), .flush(1'b0), .ev_valid(sev_valid),
    .ev_predict_t(1'b1), .ev_predict_nt(1'b0), .ev_flush_upper(1'b0),
    .ev_cond_mispredict(1'b0), .clr(1'b0), .rd_req(srd_req), .rd_addr(3'd0),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .dump_start(1'b0), .dump_valid(s_dump_valid),
    .dump_ready(1'b0), .dump_idx(s_dump_idx), .dump_data(s_dump_data), .dump_busy(s_dump_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    rd_req  = 1'b1;
    rd_addr = addr;
    step();
    rd_req  = 1'b0;
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(tag, rd_data, exp);
  endtask

  task automatic events(input int n, input logic pt, input logic pnt, input logic fu, input logic cm);
    ev_valid = 1'b1; ev_predict_t = pt; ev_predict_nt = pnt;
    ev_flush_upper = fu; ev_cond_mispredict = cm;
    repeat (n) step();
    ev_valid = 1'b0; ev_predict_t = 1'b0; ev_predict_nt = 1'b0;
    ev_flush_upper = 1'b0; ev_cond_mispredict = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  logic [31:0] exp_sw  [6];
  logic [31:0] exp_ev  [6];
  logic        pat     [4];
  logic        v_pre, xfer;
  logic [2:0]  i_pre;
  logic [31:0] d_pre;
  int          beats;

  initial begin
    exp_sw = '{32'd6, 32'd4, 32'd2, 32'd2, 32'd4, 32'd2};
`ifdef RV_BP_STAT_SNAPSHOT_EN
    exp_ev = '{32'd6, 32'd4, 32'd2, 32'd2, 32'd4, 32'd2};
`else
    exp_ev = '{32'd6, 32'd4, 32'd2, 32'd2, 32'd7, 32'd2};
`endif
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // reset state
    step(); step();
    chk("rst_rd_valid",   {31'd0, rd_valid},   32'd0);
    chk("rst_rd_data",    rd_data,             32'd0);
    chk("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_dump_idx",   {29'd0, dump_idx},   32'd0);
    chk("rst_dump_data",  dump_data,           32'd0);
    chk("rst_dump_busy",  {31'd0, dump_busy},  32'd0);
    rst = 1'b0;
    step();
    rd(3'd0, 32'd0, "rst_pred");

    // ten predicted-taken branches
    events(10, 1'b1, 1'b0, 1'b0, 1'b0);
    rd(3'd0, 32'd10, "pt_pred");
    chk("rd_valid_one_cycle_pre", {31'd0, rd_valid}, 32'd1);
    step();
    chk("rd_valid_one_cycle", {31'd0, rd_valid}, 32'd0);
    chk("rd_data_zero_idle", rd_data, 32'd0);
    rd(3'd4, 32'd10, "pt_tkp");
    rd(3'd1, 32'd10, "pt_correct");
    rd(3'd5, 32'd0,  "pt_ntkp");

    // mispredicts vs correct predictions
    do_clr();
    events(3, 1'b0, 1'b1, 1'b1, 1'b1);
    events(2, 1'b0, 1'b1, 1'b0, 1'b0);
    rd(3'd0, 32'd5, "mix_pred");
    rd(3'd1, 32'd2, "mix_correct");
    rd(3'd2, 32'd3, "mix_mispred");
    rd(3'd3, 32'd3, "mix_cond");
    rd(3'd4, 32'd0, "mix_tkp");
    rd(3'd5, 32'd5, "mix_ntkp");

    // freeze and flush block counting
    freeze = 1'b1;
    events(3, 1'b0, 1'b1, 1'b1, 1'b1);
    events(2, 1'b1, 1'b0, 1'b0, 1'b0);
    freeze = 1'b0;
    flush = 1'b1;
    events(2, 1'b1, 1'b1, 1'b0, 1'b0);
    flush = 1'b0;
    rd(3'd0, 32'd5, "frz_pred");
    rd(3'd1, 32'd2, "frz_correct");
    rd(3'd2, 32'd3, "frz_mispred");
    rd(3'd4, 32'd0, "frz_tkp");

    // out-of-range addresses with nonzero counters
    rd(3'd6, 32'd0, "addr6");
    rd(3'd7, 32'd0, "addr7");

    // clr wins over a same-cycle increment
    clr = 1'b1; ev_valid = 1'b1; ev_predict_t = 1'b1;
    step();
    clr = 1'b0; ev_valid = 1'b0; ev_predict_t = 1'b0;
    rd(3'd0, 32'd0, "clr_pred");
    rd(3'd4, 32'd0, "clr_tkp");
    rd(3'd5, 32'd0, "clr_ntkp");

    // read returns the value before a same-cycle increment
    ev_valid = 1'b1; ev_predict_t = 1'b1;
    rd(3'd0, 32'd0, "rd_pre_update");
    ev_valid = 1'b0; ev_predict_t = 1'b0;
    rd(3'd0, 32'd1, "rd_post_update");

    // 4-bit wrap and saturate boundary
    sev_valid = 1'b1;
    repeat (15) step();
    sev_valid = 1'b0;
    srd_req = 1'b1; step(); srd_req = 1'b0;
    chk("wrap_preload", {28'd0, w_rd_data}, 32'hF);
    chk("sat_preload",  {28'd0, s_rd_data}, 32'hF);
    sev_valid = 1'b1; step(); sev_valid = 1'b0;
    srd_req = 1'b1; step(); srd_req = 1'b0;
    chk("wrap_rollover", {28'd0, w_rd_data}, 32'h0);
    chk("sat_stick",     {28'd0, s_rd_data}, 32'hF);

    // sweep with stalls and an ignored restart
    do_clr();
    events(4, 1'b1, 1'b0, 1'b0, 1'b0);
    events(2, 1'b0, 1'b1, 1'b1, 1'b1);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    chk("sw_busy_start", {31'd0, dump_busy}, 32'd1);
    beats = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      dump_ready = pat[cyc % 4];
      dump_start = (cyc == 1);
      v_pre = dump_valid; i_pre = dump_idx; d_pre = dump_data;
      xfer  = v_pre && dump_ready;
      if (xfer) begin
        chk("sw_idx",  {29'd0, i_pre}, beats);
        chk("sw_data", d_pre, exp_sw[beats]);
        beats++;
      end
      step();
      dump_start = 1'b0;
      if (!xfer && v_pre) begin
        chk("sw_hold_data", dump_data, d_pre);
        chk("sw_hold_idx",  {29'd0, dump_idx}, {29'd0, i_pre});
      end
      if (xfer && beats == 6) begin
        chk("sw_last_valid", {31'd0, dump_valid}, 32'd0);
        chk("sw_done_busy",  {31'd0, dump_busy},  32'd1);
        break;
      end
    end
    dump_ready = 1'b0;
    chk("sw_beats", beats, 32'd6);
    step();
    chk("sw_busy_drop", {31'd0, dump_busy}, 32'd0);
    step();
    chk("sw_no_restart", {31'd0, dump_busy}, 32'd0);
    chk("sw_no_restart_valid", {31'd0, dump_valid}, 32'd0);

    // sweep while events keep arriving
    dump_start = 1'b1; dump_ready = 1'b1;
    step();
    dump_start = 1'b0;
    chk("ev_idx0",  {29'd0, dump_idx}, 32'd0);
    chk("ev_data0", dump_data, exp_ev[0]);
    ev_valid = 1'b1; ev_predict_t = 1'b1;
    for (int k = 1; k < 6; k++) begin
      step();
      chk("ev_idx",  {29'd0, dump_idx}, k);
      chk("ev_data", dump_data, exp_ev[k]);
    end
    step();
    ev_valid = 1'b0; ev_predict_t = 1'b0; dump_ready = 1'b0;
    chk("ev_end_valid", {31'd0, dump_valid}, 32'd0);
    step();
    chk("ev_end_busy", {31'd0, dump_busy}, 32'd0);
    rd(3'd0, 32'd12, "ev_live_pred");
    rd(3'd4, 32'd10, "ev_live_tkp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
